// File: rtl/karatsuba_pkg.sv
// karatsuba_pkg: shared widths and FSM state encoding for the Karatsuba combine block
package karatsuba_pkg;
  localparam int HALF = 16;
  localparam int ZM_W = 34;
  localparam int P_W  = 64;
  localparam int W    = 2 * HALF;
  typedef enum logic [2:0] {
    IDLE, SUB0_LO, SUB0_HI, SUB2_LO, SUB2_HI, ADD_LO, ADD_HI, DONE
  } state_e;
endpackage

// File: rtl/bk_add32.sv
// bk_add32: combinational 32-bit adder with carry-in and carry-out
module bk_add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {32'b0, cin};
endmodule

// File: rtl/karatsuba_combine_seq.sv
// karatsuba_combine_seq: combines z0/z2/zm into a 64-bit product over six passes through one 32-bit adder
module karatsuba_combine_seq
  import karatsuba_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    z0,
  input  logic [W-1:0]    z2,
  input  logic [ZM_W-1:0] zm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [P_W-1:0]  p
);
  state_e            state_q;
  logic [W-1:0]      z0_q, z2_q;
  logic [ZM_W-1:0]   zm_q, mid_q;
  logic [P_W-1:0]    p_q;
  logic              carry_q, in_ready_q, out_valid_q;
  logic [W-1:0]      add_a, add_b, add_s;
  logic              add_cin, add_cout;
  // Steer the shared adder: subtractions use a + ~b + 1 split into low/high passes
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    unique case (state_q)
      SUB0_LO: begin add_a = zm_q[W-1:0];                add_b = ~z0_q;                       add_cin = 1'b1;    end
      SUB0_HI: begin add_a = {30'b0, zm_q[ZM_W-1:W]};    add_b = '1;                          add_cin = carry_q; end
      SUB2_LO: begin add_a = mid_q[W-1:0];               add_b = ~z2_q;                       add_cin = 1'b1;    end
      SUB2_HI: begin add_a = {30'b0, mid_q[ZM_W-1:W]};   add_b = '1;                          add_cin = carry_q; end
      ADD_LO:  begin add_a = z0_q;                       add_b = {mid_q[HALF-1:0], 16'b0};    add_cin = 1'b0;    end
      ADD_HI:  begin add_a = z2_q;                       add_b = {14'b0, mid_q[ZM_W-1:HALF]}; add_cin = carry_q; end
      default: ;
    endcase
  end
  bk_add32 u_add (.a(add_a), .b(add_b), .cin(add_cin), .s(add_s), .cout(add_cout));
  // Sequencer: latch operands, walk the six adder passes, hold the product until consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      z0_q        <= '0;
      z2_q        <= '0;
      zm_q        <= '0;
      mid_q       <= '0;
      p_q         <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          z0_q       <= z0;
          z2_q       <= z2;
          zm_q       <= zm;
          in_ready_q <= 1'b0;
          state_q    <= SUB0_LO;
        end
        SUB0_LO: begin mid_q[W-1:0] <= add_s;         carry_q <= add_cout; state_q <= SUB0_HI; end
        SUB0_HI: begin mid_q[ZM_W-1:W] <= add_s[1:0]; carry_q <= add_cout; state_q <= SUB2_LO; end
        SUB2_LO: begin mid_q[W-1:0] <= add_s;         carry_q <= add_cout; state_q <= SUB2_HI; end
        SUB2_HI: begin mid_q[ZM_W-1:W] <= add_s[1:0]; carry_q <= add_cout; state_q <= ADD_LO;  end
        ADD_LO:  begin p_q[W-1:0] <= add_s;           carry_q <= add_cout; state_q <= ADD_HI;  end
        ADD_HI: begin
          p_q[P_W-1:W] <= add_s;
          carry_q      <= 1'b0;
          out_valid_q  <= 1'b1;
          state_q      <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign p         = p_q;
endmodule

// File: tb/tb_karatsuba_combine_seq.sv
// tb_karatsuba_combine_seq: vector table, corner sequences and randomized checking against a*b
module tb_karatsuba_combine_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [31:0] z0 = '0, z2 = '0;
  logic [33:0] zm = '0;
  logic [63:0] p;
  int pass_cnt = 0, tot_cnt = 0;

  typedef struct {
    logic [31:0] z0, z2;
    logic [33:0] zm;
    logic [63:0] p;
  } vec_t;
  vec_t tbl[5];

  karatsuba_combine_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .z0(z0), .z2(z2), .zm(zm), .out_valid(out_valid), .out_ready(out_ready), .p(p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic scramble();
    z0 = $urandom;
    z2 = $urandom;
    zm = 34'($urandom);
  endtask

  // Karatsuba partial products of a*b, formed from the operand halves with plain arithmetic
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] m0, output logic [31:0] m2, output logic [33:0] mm);
    m0 = a[15:0] * b[15:0];
    m2 = a[31:16] * b[31:16];
    mm = (34'(a[15:0]) + 34'(a[31:16])) * (34'(b[15:0]) + 34'(b[31:16]));
  endtask

  task automatic wait_valid(output int n);
    for (n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) break;
    end
  endtask

  task automatic run_op(input logic [31:0] a0, input logic [31:0] a2, input logic [33:0] am,
                        input logic [63:0] exp, input string nm, input int stall);
    int n;
    @(negedge clk);
    chk({nm, " in_ready idle"}, 64'(in_ready), 64'd1);
    z0 = a0; z2 = a2; zm = am; in_valid = 1'b1; out_ready = (stall == 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    scramble();
    wait_valid(n);
    chk({nm, " latency"}, 64'(n), 64'd6);
    chk({nm, " p"}, p, exp);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({nm, " hold valid"}, 64'(out_valid), 64'd1);
      chk({nm, " hold p"}, p, exp);
      chk({nm, " in_ready busy"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({nm, " back idle"}, 64'(in_ready), 64'd1);
    chk({nm, " valid drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int n, seen, sent, got, cyc;
    logic [31:0] a, b, m0, m2;
    logic [33:0] mm;
    logic [63:0] q[$];
    tbl[0] = '{32'd6, 32'd0, 34'd6, 64'h6};
    tbl[1] = '{32'd0, 32'd1, 34'd1, 64'h0000_0001_0000_0000};
    tbl[2] = '{32'hFFFE0001, 32'hFFFE0001, 34'h3_FFF8_0004, 64'hFFFF_FFFE_0000_0001};
    tbl[3] = '{32'd1, 32'd1, 34'd4, 64'h0000_0001_0002_0001};
    tbl[4] = '{32'd15, 32'd8, 34'd45, 64'h0000_0008_0016_000F};

    #1 rst = 1'b1;
    #1;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset p", p, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) run_op(tbl[i].z0, tbl[i].z2, tbl[i].zm, tbl[i].p, $sformatf("vec%0d", i), 0);

    run_op(32'd6, 32'd0, 34'd6, 64'h6, "stall3", 3);

    // in_valid presented while DONE completes must wait for IDLE
    @(negedge clk);
    z0 = 32'd1; z2 = 32'd1; zm = 34'd4; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 z0 = 32'd15; z2 = 32'd8; zm = 34'd45;
    wait_valid(n);
    chk("busy in_valid ignored p", p, 64'h0000_0001_0002_0001);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("done edge not accepted", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    scramble();
    wait_valid(n);
    chk("late accept latency", 64'(n), 64'd6);
    chk("late accept p", p, 64'h0000_0008_0016_000F);
    @(posedge clk);

    // reset during SUB2_HI abandons the operation
    @(negedge clk);
    z0 = 32'd1; z2 = 32'd1; zm = 34'd4; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midop rst in_ready", 64'(in_ready), 64'd1);
    chk("midop rst out_valid", 64'(out_valid), 64'd0);
    chk("midop rst p", p, 64'd0);
    seen = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("no valid after rst", 64'(seen), 64'd0);
    run_op(32'd6, 32'd0, 34'd6, 64'h6, "after rst", 0);

    // randomized back-to-back traffic with random backpressure
    sent = 0; got = 0; cyc = 0;
    while (got < 100 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      out_ready = $urandom_range(1, 0) == 1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rand unexpected out", 64'd1, 64'd0);
        else chk($sformatf("rand p%0d", got), p, q.pop_front());
        got++;
      end
      in_valid = 1'b0;
      scramble();
      if (sent < 100 && in_ready && $urandom_range(3, 0) != 0) begin
        a = $urandom; b = $urandom;
        model(a, b, m0, m2, mm);
        z0 = m0; z2 = m2; zm = mm; in_valid = 1'b1;
        q.push_back(64'(a) * 64'(b));
        sent++;
      end
    end
    chk("rand count", 64'(got), 64'd100);
    chk("rand queue empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/karatsuba_combine_seq.md
KARATSUBA_COMBINE_SEQ -- requirements
Module: karatsuba_combine_seq

Interface
REQ-001 The block SHALL have no parameters; half-width is fixed at 16 bits and product width at 64 bits.
REQ-002 One clock; reset is asynchronous and active-high (ports clk and rst).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  z0/z2/zm valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 z0  input  32  low partial product aL*bL.
REQ-008 z2  input  32  high partial product aH*bH.
REQ-009 zm  input  34  middle product (aL+aH)*(bL+bH).
REQ-010 out_valid  output  1  product valid.
REQ-011 out_ready  input  1  consumer accepts product.
REQ-012 p  output  64  product z2<<32 + (zm-z0-z2)<<16 + z0.

Function
REQ-013 The block SHALL compute p with exactly one 32-bit carry-in/carry-out adder instance, time-shared over six compute cycles, with a 1-bit carry register between passes.
REQ-014 States: IDLE, SUB0_LO, SUB0_HI, SUB2_LO, SUB2_HI, ADD_LO, ADD_HI, DONE; each non-IDLE, non-DONE state lasts exactly one cycle.
REQ-015 in_ready SHALL be 1 only in IDLE; in_valid&&in_ready latches z0, z2, zm into internal registers and moves to SUB0_LO.
REQ-016 SUB0_LO: zm[31:0] + ~z0, cin=1; SUB0_HI: {30'b0,zm[33:32]} + 32'hFFFFFFFF + carry; retain a 34-bit difference.
REQ-017 SUB2_LO/SUB2_HI: subtract z2 from that difference the same way, giving 34-bit mid; mid SHALL be taken modulo 2^34 (always non-negative for legal inputs).
REQ-018 ADD_LO: z0 + {mid[15:0],16'b0}, cin=0 -> p[31:0]; ADD_HI: z2 + {14'b0,mid[33:16]} + carry -> p[63:32]; final carry-out discarded.
REQ-019 After ADD_HI the FSM SHALL enter DONE; out_valid=1 only in DONE, first asserted 6 cycles after the accepting edge.
REQ-020 In DONE, p and out_valid SHALL hold stable until out_ready=1; out_valid&&out_ready returns FSM to IDLE on that edge.
REQ-021 Throughput: at most one operation per 8 cycles with out_ready held high; in_valid during non-IDLE states is ignored, inputs need not be held after acceptance.
REQ-022 in_valid asserted in the same cycle DONE completes SHALL NOT be accepted until the FSM is in IDLE (next cycle).

Reset
REQ-023 rst=1 SHALL immediately force state=IDLE, in_ready=1, out_valid=0, p=0, carry=0, operand registers=0.
REQ-024 rst asserted mid-operation SHALL abandon the computation with no out_valid pulse; first accept after rst deassert SHALL behave as from power-up.

Structure
REQ-025 The FSM state encoding and width constants (HALF=16, ZM_W=34, P_W=64) SHALL live in a shared package karatsuba_pkg.
REQ-026 The 32-bit adder SHALL be one sub-module, bk_add32 (a, b, cin -> s, cout), purely combinational; all registers reside in karatsuba_combine_seq.

Verification
REQ-027 z0=6, z2=0, zm=6 -> p=64'h6, out_valid 6 cycles after accept.
REQ-028 z0=0, z2=1, zm=1 -> p=64'h0000_0001_0000_0000 (mid=0).
REQ-029 z0=z2=32'hFFFE0001, zm=34'h3_FFF8_0004 -> p=64'hFFFF_FFFE_0000_0001 (full carry propagation).
REQ-030 out_ready low for 3 cycles in DONE -> out_valid and p stable; in_ready=0 throughout; IDLE one cycle after out_ready=1.
REQ-031 rst pulsed during SUB2_HI -> out_valid never asserted, in_ready=1 during reset; next operation (REQ-027 operands) yields p=6.
REQ-032 Back-to-back: 100 random 32x32 operand pairs, out_ready random -> every p equals reference a*b, order preserved.
